mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
// - Parametrised multi-cycle multiply/divide unit holding the HI/LO architectural registers.
// - Sits in the EX stage of the pipelined core, next to the ALU.
// - Executes mult/multu/div/divu with configurable latency and exposes busy for hazard stalls.
// - Handles mthi/mtlo writes and mfhi/mflo reads.
// - Supports cancel for exception/interrupt flush.
// PARAMETERS
// - WIDTH        32  operand, HI and LO width
// - MULT_CYCLES   5  busy cycles for mult/multu (>=1)
// - DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
// - clk      in   1      clock, rising edge
// - reset    in   1      asynchronous, active-high; clears all state
// - start    in   1      launch the operation in md_op this cycle
// - md_op    in   2      0=MULT 1=MULTU 2=DIV 3=DIVU (constants `md_mult.. in header.v)
// - a        in   WIDTH  rs operand (multiplicand / dividend)
// - b        in   WIDTH  rt operand (multiplier / divisor)
// - hi_we    in   1      mthi: HI <= wdata
// - lo_we    in   1      mtlo: LO <= wdata
// - wdata    in   WIDTH  data for mthi/mtlo
// - cancel   in   1      flush: abort in-flight op, drop start/writes this cycle
// - busy     out  1      operation in flight
// - hi       out  WIDTH  HI register (registered)
// - lo       out  WIDTH  LO register (registered)
// BEHAVIOUR
// - Reset: busy=0, hi=0, lo=0, counter=0, pending result=0.
//   Takes effect immediately, including mid-operation; the in-flight op is lost.
// - Accept rule: start is accepted only when busy=0 and cancel=0.
//   - start while busy=1: ignored, no state change. This is a protocol violation; the stall logic must prevent it.
// - On an accepted start edge:
//   - Latch the result of md_op(a,b) into pending_hi/pending_lo.
//   - Load the counter with LAT-1, where LAT = MULT_CYCLES or DIV_CYCLES.
//   - Set busy=1.
// - Each cycle while busy: counter decrements.
//   - On the edge where counter==0: HI/LO <= pending values and busy <= 0.
// - Timing: busy is high for exactly LAT cycles after the start edge. The new HI/LO are visible in the first cycle busy=0.
// - Stall contract: the core stalls any md/mf/mt instruction in D while (start | busy).
// - Arithmetic:
//   - MULT: signed 2W-bit product {HI,LO}.
//   - MULTU: unsigned 2W-bit product {HI,LO}.
//   - DIV: LO=quotient truncated toward zero; HI=remainder, sign of dividend.
//     - a=INT_MIN, b=-1: LO=INT_MIN, HI=0 (wrap, no trap).
//   - DIVU: unsigned quotient and remainder.
//   - b==0 for DIV/DIVU: busy still runs DIV_CYCLES; HI/LO are left unchanged at completion.
// - hi_we/lo_we: write on the next edge only when busy=0, start=0 and cancel=0.
//   - start+hi_we in the same cycle: start wins, the write is dropped. The decoder never issues this.
//   - hi_we and lo_we together: both registers are written with wdata.
// - cancel:
//   - While busy: busy<=0, counter cleared, HI/LO keep their pre-op values.
//   - While idle: suppresses start/hi_we/lo_we this cycle.
//   - cancel and counter==0 in the same cycle: cancel wins, no update.
// - hi/lo outputs are pure register reads. An mf* issued while busy is stalled, so it never reads stale data.
// STRUCTURE
// - header.v holds: md_op codes `md_mult/`md_multu/`md_div/`md_divu and the 2-bit md_op width macro.
// - Sub-module md_arith (combinational): takes a, b, md_op; returns {res_hi, res_lo, div_zero}.
//   - Behavioural * and / / % on WIDTH-bit operands.
//   - Signed ops are done via $signed.
// - Top level: counter of $clog2(max(MULT_CYCLES,DIV_CYCLES)+1) bits, busy flop, pending regs, HI/LO regs.
// TESTING
// 1. MULT a=32'hFFFFFFFF b=2 -> busy high 5 cycles; then hi=32'hFFFFFFFF lo=32'hFFFFFFFE.
// 2. MULTU a=32'hFFFFFFFF b=2 -> hi=1 lo=32'hFFFFFFFE.
//    DIVU a=7 b=2 -> busy high 10 cycles; then hi=1 lo=3.
// 3. DIV a=-7 b=2 -> lo=32'hFFFFFFFD hi=32'hFFFFFFFF.
//    DIV a=32'h80000000 b=-1 -> lo=32'h80000000 hi=0.
// 4. mtlo 0x1234, then DIV a=5 b=0 -> busy 10 cycles; lo stays 0x1234, hi unchanged.
// 5. MULT a=3 b=4; start MULTU a=9 b=9 at cycle 2 while busy -> ignored, final hi=0 lo=12.
//    mthi 0xAA in the same cycle as start -> hi not written by mthi.
// 6. MULT a=3 b=4 with hi=lo=0x55:
//    - cancel at cycle 3 -> busy drops next edge, hi=lo=0x55.
//    - Repeat with reset at cycle 3 -> busy=0 and hi=lo=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - operation codes and helpers for the multiply/divide unit
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    localparam int MD_OP_W = 2;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// rtl/mult_div_unit_md_arith.sv - combinational product/quotient/remainder for one md_op
module md_arith
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  md_op_e           op,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    logic [2*WIDTH-1:0]        prod_u;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]          b_safe;
    logic [WIDTH-1:0]          quo_s;
    logic [WIDTH-1:0]          rem_s;
    logic [WIDTH-1:0]          quo_u;
    logic [WIDTH-1:0]          rem_u;

    always_comb begin
        prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        prod_s   = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        div_zero = (b == '0);
        // Divisor forced non-zero so the dividers never see 0; the result is discarded anyway.
        b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
        quo_u    = a / b_safe;
        rem_u    = a % b_safe;
        // Division by -1 is negation; this also wraps INT_MIN/-1 to INT_MIN without a trap.
        if (b == '1) begin
            quo_s = '0 - a;
            rem_s = '0;
        end else begin
            quo_s = $unsigned($signed(a) / $signed(b_safe));
            rem_s = $unsigned($signed(a) % $signed(b_safe));
        end

        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[2*WIDTH-1:WIDTH];
                res_lo = prod_s[WIDTH-1:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[2*WIDTH-1:WIDTH];
                res_lo = prod_u[WIDTH-1:0];
            end
            MD_DIV: begin
                res_hi = rem_s;
                res_lo = quo_s;
            end
            default: begin
                res_hi = rem_u;
                res_lo = quo_u;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               cancel,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int                CNT_W     = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0]  MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_op_e           op;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_dz;

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic             pend_dz_q, pend_dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    assign op = md_op_e'(md_op);

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .a        (a),
        .b        (b),
        .op       (op),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (res_dz)
    );

    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (busy_q) begin
            if (cancel) begin
                // Flush beats completion: HI/LO keep their pre-op values.
                busy_d = 1'b0;
                cnt_d  = '0;
            end else if (cnt_q == '0) begin
                busy_d = 1'b0;
                if (!pend_dz_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (!cancel) begin
            if (start) begin
                // Result is captured at launch; the busy window only models latency.
                pend_hi_d = res_hi;
                pend_lo_d = res_lo;
                pend_dz_d = is_div(op) && res_dz;
                cnt_d     = is_div(op) ? DIV_LOAD : MULT_LOAD;
                busy_d    = 1'b1;
            end else begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;
    int cyc;

    mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch an op at a negedge, then count negedges with busy high (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] ra, input logic [31:0] rb,
                          output int n);
        @(negedge clk);
        start = 1'b1; md_op = op; a = ra; b = rb;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_hl(input logic whi, input logic wlo, input logic [31:0] d);
        @(negedge clk);
        hi_we = whi; lo_we = wlo; wdata = d;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; md_op = 2'd0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_hi", hi, 32'd0);
        check_eq("reset_lo", lo, 32'd0);

        run_op(2'd0, 32'hFFFFFFFF, 32'd2, cyc);
        check_eq("mult_cycles", cyc, 32'd5);
        check_eq("mult_hi", hi, 32'hFFFFFFFF);
        check_eq("mult_lo", lo, 32'hFFFFFFFE);

        run_op(2'd1, 32'hFFFFFFFF, 32'd2, cyc);
        check_eq("multu_hi", hi, 32'd1);
        check_eq("multu_lo", lo, 32'hFFFFFFFE);

        run_op(2'd3, 32'd7, 32'd2, cyc);
        check_eq("divu_cycles", cyc, 32'd10);
        check_eq("divu_hi", hi, 32'd1);
        check_eq("divu_lo", lo, 32'd3);

        run_op(2'd2, 32'hFFFFFFF9, 32'd2, cyc);
        check_eq("div_neg_lo", lo, 32'hFFFFFFFD);
        check_eq("div_neg_hi", hi, 32'hFFFFFFFF);

        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, cyc);
        check_eq("div_ovf_lo", lo, 32'h80000000);
        check_eq("div_ovf_hi", hi, 32'd0);

        write_hl(1'b1, 1'b0, 32'h0000BEEF);
        write_hl(1'b0, 1'b1, 32'h00001234);
        check_eq("mthi", hi, 32'h0000BEEF);
        check_eq("mtlo", lo, 32'h00001234);
        run_op(2'd2, 32'd5, 32'd0, cyc);
        check_eq("divz_cycles", cyc, 32'd10);
        check_eq("divz_lo", lo, 32'h00001234);
        check_eq("divz_hi", hi, 32'h0000BEEF);

        // Start while busy is ignored; mthi alongside start is dropped.
        @(negedge clk);
        start = 1'b1; md_op = 2'd0; a = 32'd3; b = 32'd4; hi_we = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check_eq("mthi_vs_start", hi, 32'h0000BEEF);
        @(negedge clk);
        start = 1'b1; md_op = 2'd1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (busy && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check_eq("busy_ign_cycles", cyc, 32'd5);
        check_eq("busy_ign_hi", hi, 32'd0);
        check_eq("busy_ign_lo", lo, 32'd12);

        // Cancel mid-operation.
        write_hl(1'b1, 1'b1, 32'h55);
        check_eq("mthl_both_hi", hi, 32'h55);
        check_eq("mthl_both_lo", lo, 32'h55);
        @(negedge clk);
        start = 1'b1; md_op = 2'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check_eq("cancel_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check_eq("cancel_hi", hi, 32'h55);
        check_eq("cancel_lo", lo, 32'h55);

        // Cancel on the completion cycle (counter==0 during cycle 5).
        @(negedge clk);
        start = 1'b1; md_op = 2'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("cancel_last_busy_pre", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check_eq("cancel_last_busy", {31'd0, busy}, 32'd0);
        check_eq("cancel_last_lo", lo, 32'h55);

        // Cancel while idle suppresses start.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; md_op = 2'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check_eq("cancel_idle_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1; md_op = 2'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("areset_busy", {31'd0, busy}, 32'd0);
        check_eq("areset_hi", hi, 32'd0);
        check_eq("areset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("post_reset_lo", lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
